// File: rtl/heartbeat_decoder_pkg.sv
// Shared types and constants for the heartbeat Manchester decoder.
package heartbeat_decoder_pkg;

  localparam int WORD_W = 8;
  localparam int HIST_W = 2 * WORD_W;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_e;

  typedef enum logic [1:0] {
    UNKNOWN,
    MID,
    BOUNDARY
  } phase_e;

endpackage

// File: rtl/heartbeat_decoder_if.sv
// Line input and decoded-word outputs of the heartbeat decoder.
interface heartbeat_decoder_if;

  logic                                   signal;
  logic [heartbeat_decoder_pkg::WORD_W-1:0] word;
  logic                                   word_valid;
  logic                                   locked;
  logic                                   seq_error;
  logic [7:0]                             err_count;
  logic                                   idle;

  modport slave (
    input  signal,
    output word, word_valid, locked, seq_error, err_count, idle
  );

  modport master (
    output signal,
    input  word, word_valid, locked, seq_error, err_count, idle
  );

endinterface

// File: rtl/heartbeat_bit_slicer.sv
// Synchronizes the Manchester line, measures edge intervals and tracks bit
// phase, emitting one decoded bit per mid-bit edge.
module heartbeat_bit_slicer
  import heartbeat_decoder_pkg::*;
#(
  parameter int LONG_THRESH  = 12,
  parameter int MIN_INTERVAL = 3,
  parameter int TIMEOUT      = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic signal_i,
  output logic bit_valid_o,
  output logic bit_value_o,
  output logic symbol_err_o,
  output logic idle_o
);

  localparam logic [7:0] LONG_C    = 8'(LONG_THRESH);
  localparam logic [7:0] MIN_C     = 8'(MIN_INTERVAL);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0] sync_q;
  logic       prev_q;
  logic [7:0] cnt_q, cnt_d;
  phase_e     phase_q, phase_d;
  logic       idle_q, idle_d;
  logic       edge_det;

  // NOTE: async reset in the sensitivity list; every state flop uses <= so all
  // registers sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      prev_q  <= 1'b0;
      cnt_q   <= 8'd0;
      phase_q <= UNKNOWN;
      idle_q  <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], signal_i};
      prev_q  <= sync_q[1];
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      idle_q  <= idle_d;
    end
  end

  assign edge_det    = sync_q[1] ^ prev_q;
  assign bit_value_o = prev_q;
  assign idle_o      = idle_q;

  // NOTE: every output of this block gets a default first, so no latches.
  always_comb begin
    cnt_d        = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    phase_d      = phase_q;
    idle_d       = idle_q;
    bit_valid_o  = 1'b0;
    symbol_err_o = 1'b0;
    if (edge_det) begin
      cnt_d  = 8'd1;
      idle_d = 1'b0;
      // The interval ending in the edge that leaves idle carries no timing.
      if (!idle_q) begin
        if (cnt_q < MIN_C) begin
          symbol_err_o = 1'b1;
          phase_d      = UNKNOWN;
        end else if (cnt_q >= LONG_C) begin
          if (phase_q == BOUNDARY) begin
            symbol_err_o = 1'b1;
            phase_d      = UNKNOWN;
          end else begin
            phase_d     = MID;
            bit_valid_o = 1'b1;
          end
        end else begin
          case (phase_q)
            MID:      phase_d = BOUNDARY;
            BOUNDARY: begin
              phase_d     = MID;
              bit_valid_o = 1'b1;
            end
            default:  phase_d = UNKNOWN;
          endcase
        end
      end
    end else if (!idle_q && cnt_d == TIMEOUT_C) begin
      idle_d  = 1'b1;
      phase_d = UNKNOWN;
    end
  end

endmodule

// File: rtl/heartbeat_decoder.sv
// Heartbeat counter decoder: word alignment FSM, sequence checking and error
// accounting on top of the Manchester bit slicer.
module heartbeat_decoder
  import heartbeat_decoder_pkg::*;
#(
  parameter int LONG_THRESH  = 12,
  parameter int MIN_INTERVAL = 3,
  parameter int TIMEOUT      = 64
) (
  input  logic                clk,
  input  logic                rst,
  heartbeat_decoder_if.slave  bus
);

  logic bit_valid, bit_value, symbol_err, idle;

  heartbeat_bit_slicer #(
    .LONG_THRESH  (LONG_THRESH),
    .MIN_INTERVAL (MIN_INTERVAL),
    .TIMEOUT      (TIMEOUT)
  ) u_slicer (
    .clk          (clk),
    .rst          (rst),
    .signal_i     (bus.signal),
    .bit_valid_o  (bit_valid),
    .bit_value_o  (bit_value),
    .symbol_err_o (symbol_err),
    .idle_o       (idle)
  );

  state_e              state_q, state_d;
  logic [HIST_W-1:0]   hist_q, hist_d;
  logic [4:0]          seen_q, seen_d;
  logic [2:0]          bcnt_q, bcnt_d;
  logic                mism_q, mism_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [7:0]          errc_q, errc_d;
  logic                wv_q, wv_d;
  logic                seq_q, seq_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      hist_q  <= '0;
      seen_q  <= 5'd0;
      bcnt_q  <= 3'd0;
      mism_q  <= 1'b0;
      word_q  <= '0;
      errc_q  <= 8'd0;
      wv_q    <= 1'b0;
      seq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      seen_q  <= seen_d;
      bcnt_q  <= bcnt_d;
      mism_q  <= mism_d;
      word_q  <= word_d;
      errc_q  <= errc_d;
      wv_q    <= wv_d;
      seq_q   <= seq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    seen_d  = seen_q;
    bcnt_d  = bcnt_q;
    mism_d  = mism_q;
    word_d  = word_q;
    errc_d  = errc_q;
    wv_d    = 1'b0;
    seq_d   = 1'b0;
    if (symbol_err || idle) begin
      state_d = HUNT;
      seen_d  = 5'd0;
      bcnt_d  = 3'd0;
      mism_d  = 1'b0;
    end else if (bit_valid) begin
      hist_d = {hist_q[HIST_W-2:0], bit_value};
      case (state_q)
        HUNT: begin
          // Seen count saturates at one full history so stale bits never match.
          if (seen_q != 5'd16) seen_d = seen_q + 5'd1;
          if (seen_d == 5'd16 && hist_d[15:8] + 8'd1 == hist_d[7:0]) begin
            state_d = LOCKED;
            word_d  = hist_d[7:0];
            wv_d    = 1'b1;
            bcnt_d  = 3'd0;
            mism_d  = 1'b0;
          end
        end
        LOCKED: begin
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            word_d = hist_d[7:0];
            wv_d   = 1'b1;
            if (hist_d[7:0] != word_q + 8'd1) begin
              seq_d  = 1'b1;
              mism_d = 1'b1;
              if (mism_q) state_d = HUNT;
            end else begin
              mism_d = 1'b0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if ((symbol_err || seq_d) && errc_q != 8'hFF) errc_d = errc_q + 8'd1;
  end

  assign bus.word       = word_q;
  assign bus.word_valid = wv_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.seq_error  = seq_q;
  assign bus.err_count  = errc_q;
  assign bus.idle       = idle;

endmodule

// File: tb/tb_heartbeat_decoder.sv
// Scoreboard bench for heartbeat_decoder: Manchester stimulus with a word-level
// reference model of alignment, sequence checking and error counting.
module tb_heartbeat_decoder;
  import heartbeat_decoder_pkg::*;

  localparam int HALF    = 8;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst;

  heartbeat_decoder_if bus ();

  heartbeat_decoder #(
    .LONG_THRESH  (12),
    .MIN_INTERVAL (3),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] word;
    logic       seq;
    logic       locked;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  state_e      m_state = HUNT;
  logic [15:0] m_hist  = '0;
  int          m_seen  = 0;
  int          m_cnt   = 0;
  logic        m_mism  = 1'b0;
  logic [7:0]  m_ref   = 8'h00;
  int          m_errc  = 0;

  // Phase-acquisition bookkeeping for the stimulus
  logic acq       = 1'b0;
  int   skip_left = 0;
  logic prev_bit  = 1'b0;

  task automatic model_reset();
    m_state = HUNT; m_hist = '0; m_seen = 0; m_cnt = 0;
    m_mism = 1'b0; m_ref = 8'h00; m_errc = 0;
  endtask

  task automatic model_hunt();
    m_state = HUNT; m_seen = 0; m_cnt = 0; m_mism = 1'b0;
  endtask

  task automatic model_sym_err();
    if (m_errc < 255) m_errc++;
    model_hunt();
    acq       = 1'b0;
    skip_left = 1;
  endtask

  task automatic model_bit(input logic b);
    exp_t e;
    m_hist = {m_hist[14:0], b};
    if (m_state == HUNT) begin
      if (m_seen < 16) m_seen++;
      if (m_seen >= 16 && 8'(m_hist[15:8] + 8'd1) == m_hist[7:0]) begin
        m_state = LOCKED; m_cnt = 0; m_mism = 1'b0; m_ref = m_hist[7:0];
        e.word = m_ref; e.seq = 1'b0; e.locked = 1'b1;
        sb_q.push_back(e);
      end
    end else begin
      m_cnt++;
      if (m_cnt == 8) begin
        m_cnt    = 0;
        e.word   = m_hist[7:0];
        e.seq    = (e.word != 8'(m_ref + 8'd1));
        e.locked = 1'b1;
        if (e.seq) begin
          if (m_errc < 255) m_errc++;
          if (m_mism) begin
            m_state  = HUNT;
            e.locked = 1'b0;
          end
          m_mism = 1'b1;
        end else begin
          m_mism = 1'b0;
        end
        m_ref = e.word;
        sb_q.push_back(e);
      end
    end
  endtask

  // A bit is decoded once phase is known; phase comes from the first long
  // interval, i.e. the first bit differing from its predecessor.
  task automatic model_rx(input logic b);
    if (acq) model_bit(b);
    else if (skip_left == 0 && b != prev_bit) begin
      acq = 1'b1;
      model_bit(b);
    end else if (skip_left > 0) skip_left--;
    prev_bit = b;
  endtask

  task automatic line_hold(input logic lvl, input int n);
    bus.signal = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    model_rx(b);
    line_hold(b, HALF);
    if (glitch) begin
      line_hold(~b, 3);
      line_hold(b, 2);
      line_hold(~b, 3);
      model_sym_err();
    end else begin
      line_hold(~b, HALF);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input int glitch_bit);
    for (int i = 7; i >= 0; i--) send_bit(w[i], (7 - i) == glitch_bit);
  endtask

  // Park the line until idle, then a one-bit preamble opposite the first MSB.
  task automatic start_stream(input logic [7:0] first);
    logic msb;
    msb = first[7];
    line_hold(msb, TIMEOUT + 16);
    model_hunt();
    acq       = 1'b0;
    skip_left = 0;
    prev_bit  = ~msb;
    line_hold(~msb, HALF);
    line_hold(msb, HALF);
  endtask

  task automatic finish_stream(input string tag);
    repeat (24) @(posedge clk);
    @(negedge clk);
    check({tag, "_sb_drained"}, sb_q.size(), 0);
    check({tag, "_err_count"}, bus.err_count, m_errc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.word_valid) begin
        if (sb_q.size() == 0) check("sb_expected_word", 0, 1);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          check("word", bus.word, e.word);
          check("seq_error", bus.seq_error, e.seq);
          check("locked_at_word", bus.locked, e.locked);
        end
      end else if (bus.seq_error) begin
        check("seq_error_without_word", bus.seq_error, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    bus.signal = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_word", bus.word, 8'h00);
    check("rst_word_valid", bus.word_valid, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_seq_error", bus.seq_error, 0);
    check("rst_err_count", bus.err_count, 0);
    check("rst_idle", bus.idle, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic lock on a counting stream
    start_stream(8'h10);
    send_word(8'h10, -1);
    send_word(8'h11, -1);
    send_word(8'h12, -1);

    // Line held: idle must not rise early, then must rise and drop lock
    repeat (52) @(posedge clk);
    @(negedge clk);
    check("idle_early", bus.idle, 0);
    check("locked_before_idle", bus.locked, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("idle_asserted", bus.idle, 1);
    check("locked_after_idle", bus.locked, 0);
    check("basic_sb_drained", sb_q.size(), 0);
    check("basic_word", bus.word, 8'h12);
    model_hunt();
    @(posedge clk); #1;
    bus.signal = ~bus.signal;
    @(negedge clk);
    check("idle_held_until_edge", bus.idle, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_cleared_by_edge", bus.idle, 0);

    // Wrap-around 0xFF -> 0x00
    start_stream(8'hFE);
    send_word(8'hFE, -1);
    send_word(8'hFF, -1);
    send_word(8'h00, -1);
    send_word(8'h01, -1);
    finish_stream("wrap");
    check("wrap_word", bus.word, 8'h01);

    // Single mismatch stays locked, second consecutive one drops lock
    start_stream(8'h1F);
    send_word(8'h1F, -1);
    send_word(8'h20, -1);
    send_word(8'h21, -1);
    send_word(8'h55, -1);
    send_word(8'h56, -1);
    check("seq_single_err_count", bus.err_count, 1);
    check("seq_single_locked", bus.locked, 1);
    send_word(8'h30, -1);
    send_word(8'h70, -1);
    finish_stream("seq");
    check("seq_double_locked", bus.locked, 0);
    check("seq_double_err_count", bus.err_count, 3);

    // Glitch inside a half bit, then relock
    start_stream(8'h80);
    send_word(8'h80, -1);
    send_word(8'h81, -1);
    send_word(8'h82, 1);
    check("glitch_hunt", bus.locked, 0);
    check("glitch_err_count", bus.err_count, 4);
    send_word(8'h83, -1);
    send_word(8'h84, -1);
    send_word(8'h85, -1);
    check("glitch_relocked", bus.locked, 1);
    finish_stream("glitch");
    check("glitch_word", bus.word, 8'h85);

    // Asynchronous reset in the middle of a word while locked
    start_stream(8'h40);
    send_word(8'h40, -1);
    send_word(8'h41, -1);
    check("pre_rst_locked", bus.locked, 1);
    for (int i = 7; i >= 4; i--) send_bit(1'(8'h42 >> i), 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_word", bus.word, 8'h00);
    check("arst_word_valid", bus.word_valid, 0);
    check("arst_locked", bus.locked, 0);
    check("arst_seq_error", bus.seq_error, 0);
    check("arst_err_count", bus.err_count, 0);
    check("arst_idle", bus.idle, 1);
    sb_q.delete();
    model_reset();
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;

    // Decoding restarts cleanly after reset
    start_stream(8'h60);
    send_word(8'h60, -1);
    send_word(8'h61, -1);
    finish_stream("post_rst");
    check("post_rst_locked", bus.locked, 1);
    check("post_rst_word", bus.word, 8'h61);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/heartbeat_decoder.md
HEARTBEAT_DECODER -- requirements
Module: heartbeat_decoder

Interface
REQ-001 Parameter LONG_THRESH, default 12: edge interval (clk cycles) at or above which the interval is "long" (one full bit); below it is "short" (half bit).
REQ-002 Parameter MIN_INTERVAL, default 3: intervals below this count are a symbol error.
REQ-003 Parameter TIMEOUT, default 64: cycles without a line edge before the line is declared idle.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 signal  input  1  Manchester line from a heartbeat transmitter, asynchronous to clk.
REQ-007 word  output  8  last decoded counter word, MSB received first.
REQ-008 word_valid  output  1  one-cycle pulse when word updates.
REQ-009 locked  output  1  high while word alignment is established.
REQ-010 seq_error  output  1  one-cycle pulse when a locked word is not previous word + 1 (mod 256).
REQ-011 err_count  output  8  saturating count of seq_error pulses plus symbol errors.
REQ-012 idle  output  1  high while no edge has been seen for TIMEOUT cycles.

Function
REQ-013 Line encoding: each bit is two equal halves; first half = bit, second half = !bit; a 1 has a mid-bit 1->0 edge, a 0 has a 0->1 edge.
REQ-014 signal passes a 2-flop synchronizer, then an edge detector; decode latency from line edge to internal edge event is 3 clk cycles.
REQ-015 An 8-bit interval counter restarts at 1 on each edge and saturates at 255.
REQ-016 Phase tracking: a long interval marks the ending edge as mid-bit; after a mid-bit edge, a short interval marks a boundary edge; after a boundary edge, a short interval marks a mid-bit edge; a long interval after a boundary edge is a symbol error.
REQ-017 Phase is unknown after reset, symbol error or idle; no bits are emitted until the first long interval.
REQ-018 At every mid-bit edge the decoded bit = synchronized level just before the edge; it shifts into a 16-bit history register at the LSB.
REQ-019 State HUNT: after each decoded bit, with at least 16 bits held since phase acquisition, if history[15:8] + 1 == history[7:0] (mod 256), go to LOCKED, load word = history[7:0], pulse word_valid and clear the bit counter.
REQ-020 State LOCKED: every 8th decoded bit loads word = history[7:0] and pulses word_valid; if the new word != previous word + 1, seq_error pulses in the same cycle.
REQ-021 Two consecutive mismatching words in LOCKED go to HUNT; a single mismatch stays LOCKED and the new word becomes the reference.
REQ-022 Word 0xFF followed by 0x00 is a valid increment (wrap-around).
REQ-023 Symbol error (REQ-002, REQ-016) or idle assertion: go to HUNT, clear phase and bit count, increment err_count (idle does not increment it).
REQ-024 idle asserts when the interval counter reaches TIMEOUT and deasserts on the next edge.
REQ-025 err_count saturates at 255; a seq_error and a symbol error in the same cycle add one.
REQ-026 locked = (state == LOCKED); word holds its value across HUNT.

Reset
REQ-027 On rst: state HUNT, word 0x00, word_valid 0, locked 0, seq_error 0, err_count 0, idle 1, history, interval, phase and bit counters cleared, synchronizer flops 0.
REQ-028 rst mid-word discards the partial word; decoding restarts from REQ-017 after release.

Structure
REQ-029 A shared package holds the state enum (HUNT, LOCKED), the phase enum (UNKNOWN, MID, BOUNDARY), and the word width constant 8.
REQ-030 One sub-module, heartbeat_bit_slicer (synchronizer, edge detector, interval counter, phase tracker), outputs bit_valid, bit_value, symbol_err and idle; the top holds the alignment FSM and the counters.

Verification
REQ-031 Half-bit 8 cycles, words 0x10,0x11,0x12 -> locked after 0x11, word_valid with word 0x11 then 0x12, seq_error never asserted.
REQ-032 Words 0xFE,0xFF,0x00,0x01 -> 0x00 and 0x01 accepted, seq_error never asserted.
REQ-033 When locked on 0x20, then 0x21,0x55,0x56 -> one seq_error at 0x55, stays locked, err_count 1; then 0x30,0x70 -> second mismatch, locked deasserts.
REQ-034 A 2-cycle glitch inside a half bit -> symbol error, err_count +1, HUNT, relock within 3 good words.
REQ-035 Line held constant for 64 cycles -> idle asserts, state HUNT; restart the stream -> idle deasserts on the first edge.
REQ-036 Assert rst mid-word while locked -> all outputs at REQ-027 values, asynchronously, before the next clk edge.
